// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory word-write port of the program loader.
//
// Byte handshake: the source holds rx_data stable while rx_valid is high.
// A byte is consumed on the rising clk edge where rx_valid && rx_ready are both 1.
// rx_ready does not depend on rx_valid, and rx_valid may drop between bytes at any time.
// The imem write side has no back-pressure. The word is written on every cycle with imem_we=1.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    // Byte source plus the memory that receives the writes
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    // The loader itself
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: reads a byte stream with a 2-byte word count and then 4*N
// little-endian data bytes, and writes each assembled word into instruction memory.
// The CPU is held in stall while a session is in progress.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load_start,
    imem_loader_if.slave  bus,
    output logic          o_cpu_hold,
    output logic          o_load_done,
    output logic          o_load_err,
    output logic [AW:0]   o_words_loaded,
    output logic [2:0]    o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_len;
    logic [31:0] r_word;
    logic [1:0]  r_byte_cnt;
    logic [AW:0] r_word_idx;

    logic        w_rx_ready;
    logic        w_take;
    logic [15:0] w_len;
    logic [15:0] w_idx_inc;

    assign w_take    = bus.rx_valid && w_rx_ready;
    // Full count as seen while the high byte is on the bus
    assign w_len     = {bus.rx_data, r_len[7:0]};
    assign w_idx_inc = 16'(r_word_idx) + 16'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_load_start) w_next = S_LEN0;
            S_LEN0:  if (w_take) w_next = S_LEN1;
            S_LEN1: begin
                if (w_take) begin
                    if (w_len == 16'd0)             w_next = S_DONE;
                    else if (w_len > 16'(DEPTH))    w_next = S_ERR;
                    else                            w_next = S_DATA;
                end
            end
            S_DATA:  if (w_take && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
            S_WRITE: w_next = (w_idx_inc == r_len) ? S_DONE : S_DATA;
            S_DONE:  if (i_load_start) w_next = S_LEN0;
            S_ERR:   if (i_load_start) w_next = S_LEN0;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: word count, byte assembly (LSB first) and word index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len      <= 16'd0;
            r_word     <= 32'd0;
            r_byte_cnt <= 2'd0;
            r_word_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_load_start) begin
                        r_byte_cnt <= 2'd0;
                        r_word_idx <= '0;
                    end
                end
                S_LEN0:  if (w_take) r_len[7:0]  <= bus.rx_data;
                S_LEN1:  if (w_take) r_len[15:8] <= bus.rx_data;
                S_DATA: begin
                    if (w_take) begin
                        r_word     <= {bus.rx_data, r_word[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_WRITE: r_word_idx <= r_word_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        w_rx_ready  = 1'b0;
        bus.imem_we = 1'b0;
        o_cpu_hold  = 1'b0;
        o_load_done = 1'b0;
        o_load_err  = 1'b0;
        case (r_state)
            S_LEN0, S_LEN1, S_DATA: begin
                w_rx_ready = 1'b1;
                o_cpu_hold = 1'b1;
            end
            S_WRITE: begin
                bus.imem_we = 1'b1;
                o_cpu_hold  = 1'b1;
            end
            S_DONE:  o_load_done = 1'b1;
            S_ERR:   o_load_err  = 1'b1;
            default: ;
        endcase
    end

    assign bus.rx_ready   = w_rx_ready;
    assign bus.imem_addr  = 32'({r_word_idx[AW-1:0], 2'b00});
    assign bus.imem_wdata = r_word;
    assign o_words_loaded = r_word_idx;
    assign o_state        = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed byte streams, a session-level model that
// predicts the write sequence and final status, and a per-cycle compare process.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;
  logic [2:0]    dbg_state;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load_start   (load_start),
    .bus            (bus),
    .o_cpu_hold     (cpu_hold),
    .o_load_done    (load_done),
    .o_load_err     (load_err),
    .o_words_loaded (words_loaded),
    .o_state        (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [31:0] last_addr = 32'hFFFF_FFFF;

  logic [31:0] exp_q[$];       // expected write data, in order
  logic [31:0] exp_addr_q[$];  // expected write addresses, in order
  logic [7:0]  stim_q[$];      // byte stream of the current session

  logic [31:0] mem [0:DEPTH-1];        // the instruction memory being loaded
  logic [31:0] model_mem [0:DEPTH-1];  // image the model expects
  logic        exp_done;
  logic        exp_err;
  int          exp_words;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory behind the write port
  always @(posedge clk) begin
    if (bus.imem_we) mem[bus.imem_addr[7:2]] <= bus.imem_wdata;
  end

  // Compare process: every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      // Bytes are accepted only while a session is loading and not writing
      check("rx_ready_rule", {31'd0, bus.rx_ready}, {31'd0, cpu_hold & ~bus.imem_we});
      check("done_err_excl", {31'd0, load_done & load_err}, 32'd0);
      if (bus.imem_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %h data %h, expected none", bus.imem_addr, bus.imem_wdata);
        end else begin
          check("write_addr", bus.imem_addr, exp_addr_q.pop_front());
          check("write_data", bus.imem_wdata, exp_q.pop_front());
          check("hold_in_write", {31'd0, cpu_hold}, 32'd1);
        end
        last_addr = bus.imem_addr;
        n_writes++;
      end
    end
  end

  // ---------------- model ----------------
  // From the byte stream alone: count N, then N little-endian words written to 0,4,8,...
  task automatic model_session();
    int n;
    logic [31:0] w;
    n = int'({stim_q[1], stim_q[0]});
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_words = 0;
    if (n == 0) begin
      exp_done = 1'b1;
    end else if (n > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      exp_done  = 1'b1;
      exp_words = n;
      for (int i = 0; i < n; i++) begin
        w = {stim_q[2+4*i+3], stim_q[2+4*i+2], stim_q[2+4*i+1], stim_q[2+4*i]};
        exp_q.push_back(w);
        exp_addr_q.push_back(32'(i * 4));
        model_mem[i] = w;
      end
    end
  endtask

  task automatic build_stream(input int n, input logic [31:0] base, input int data_words);
    logic [31:0] w;
    stim_q.delete();
    stim_q.push_back(8'(n));
    stim_q.push_back(8'(n >> 8));
    for (int i = 0; i < data_words; i++) begin
      w = base + 32'(i) * 32'h0102_0305;
      stim_q.push_back(w[7:0]);
      stim_q.push_back(w[15:8]);
      stim_q.push_back(w[23:16]);
      stim_q.push_back(w[31:24]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Present one byte until it is taken; leaves rx_valid high.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: byte %h not taken within 200 cycles", b);
    end
    @(posedge clk); #1;
  endtask

  // Send stim_q[lo..hi] with random idle gaps of 0..gap_max cycles after each byte
  task automatic send_range(input int lo, input int hi, input int gap_max);
    int g;
    for (int i = lo; i <= hi; i++) begin
      send_byte(stim_q[i]);
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) begin
        bus.rx_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (load_done || load_err) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done/err within 2000 cycles", name);
    end
  endtask

  task automatic finish_session(input string name);
    wait_end(name);
    check({name, "_done"},  {31'd0, load_done}, {31'd0, exp_done});
    check({name, "_err"},   {31'd0, load_err},  {31'd0, exp_err});
    check({name, "_words"}, 32'(words_loaded), 32'(exp_words));
    check({name, "_hold"},  {31'd0, cpu_hold},  32'd0);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < exp_words; i++) check({name, "_mem"}, mem[i], model_mem[i]);
  endtask

  task automatic run_session(input string name, input int gap_max);
    model_session();
    pulse_start();
    send_range(0, stim_q.size() - 1, gap_max);
    finish_session(name);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    check({name, "_we"},    {31'd0, bus.imem_we},  32'd0);
    check({name, "_hold"},  {31'd0, cpu_hold},     32'd0);
    check({name, "_done"},  {31'd0, load_done},    32'd0);
    check({name, "_err"},   {31'd0, load_err},     32'd0);
    check({name, "_words"}, 32'(words_loaded),     32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    rst_n        = 1'b0;
    load_start   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: N=2 program, hand-computed words
    stim_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'ha0, 8'h00};
    model_session();
    check("model_w0", exp_q[0], 32'h0050_0093);
    check("model_w1", exp_q[1], 32'h00a0_0113);
    pulse_start();
    send_range(0, 5, 0);
    check("we_latency", {31'd0, bus.imem_we}, 32'd1);
    send_range(6, 9, 0);
    finish_session("t1");
    check("t1_mem0", mem[0], 32'h0050_0093);
    check("t1_mem1", mem[1], 32'h00a0_0113);
    check("t1_last_addr", last_addr, 32'h0000_0004);

    // 2: N=0, done the cycle after the second byte
    stim_q = '{8'h00, 8'h00};
    model_session();
    pulse_start();
    check("restart_clears_done", {31'd0, load_done}, 32'd0);
    check("restart_clears_words", 32'(words_loaded), 32'd0);
    check("restart_hold", {31'd0, cpu_hold}, 32'd1);
    w0 = n_writes;
    send_range(0, 1, 0);
    check("n0_done_next_cycle", {31'd0, load_done}, 32'd1);
    finish_session("t2");
    check("t2_no_write", 32'(n_writes - w0), 32'd0);

    // 3: N=65 rejected; excess bytes not consumed
    stim_q = '{8'h41, 8'h00};
    model_session();
    w0 = n_writes;
    pulse_start();
    send_range(0, 1, 0);
    check("n65_err_next_cycle", {31'd0, load_err}, 32'd1);
    finish_session("t3");
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'haa;
    repeat (6) begin
      @(negedge clk);
      check("err_no_ready", {31'd0, bus.rx_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    check("t3_no_write", 32'(n_writes - w0), 32'd0);
    check("err_holds", {31'd0, load_err}, 32'd1);

    // 3b: N=64 fills memory, continuous valid
    build_stream(64, 32'hC0DE_0001, 64);
    run_session("t3b", 0);
    check("n64_last_addr", last_addr, 32'h0000_00FC);
    check("n64_words", 32'(words_loaded), 32'd64);

    // 4: same image with continuous valid and with random gaps
    build_stream(8, 32'h1234_5678, 8);
    run_session("t4a", 0);
    run_session("t4b", 3);
    check("t4_mem7", mem[7], 32'h1234_5678 + 32'd7 * 32'h0102_0305);

    // 5: reset after 2 data bytes of word 1
    build_stream(2, 32'hDEAD_0000, 2);
    model_session();
    pulse_start();
    send_range(0, 7, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    check("word0_intact", mem[0], 32'hDEAD_0000);
    @(posedge clk); #1;
    build_stream(2, 32'h0BAD_F00D, 2);
    run_session("t5", 2);

    // 6: load_start in DATA ignored, then restart from DONE with N=1
    build_stream(2, 32'h5555_AAAA, 2);
    model_session();
    pulse_start();
    send_range(0, 4, 0);
    pulse_start();
    check("start_ignored_hold", {31'd0, cpu_hold}, 32'd1);
    send_range(5, stim_q.size() - 1, 0);
    finish_session("t6a");
    build_stream(1, 32'h7777_0001, 1);
    w0 = n_writes;
    run_session("t6b", 0);
    check("t6b_one_write", 32'(n_writes - w0), 32'd1);
    check("t6b_addr0", last_addr, 32'd0);
    check("t6b_mem1_kept", mem[1], 32'h5555_AAAA + 32'h0102_0305);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
